// File: rtl/playlist_mcu.sv
// Playlist control unit: tracks the current song index and the play/pause state.
// Button edges drive a three-state FSM; a one-cycle LOAD state pulses reset_player.
module playlist_mcu #(
    parameter int NUM_SONGS         = 4,
    parameter bit KEEP_PLAY_ON_SKIP = 1'b0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         play_button,
    input  logic                         next_button,
    input  logic                         prev_button,
    input  logic                         song_done,
    input  logic [1:0]                   mode,
    output logic                         play,
    output logic                         reset_player,
    output logic [$clog2(NUM_SONGS)-1:0] song
);

    localparam int            SW   = $clog2(NUM_SONGS);
    localparam logic [SW-1:0] LAST = SW'(NUM_SONGS - 1);

    typedef enum logic [1:0] {PAUSED, PLAYING, LOAD} state_t;

    state_t state;
    logic   resume;
    logic   play_q, next_q, prev_q, done_q;
    logic   play_ev, next_ev, prev_ev, done_ev;

    assign play_ev = play_button & ~play_q;
    assign next_ev = next_button & ~next_q;
    assign prev_ev = prev_button & ~prev_q;
    assign done_ev = song_done   & ~done_q;

    function automatic logic [SW-1:0] inc(input logic [SW-1:0] s);
        return (s == LAST) ? '0 : s + 1'b1;
    endfunction

    function automatic logic [SW-1:0] dec(input logic [SW-1:0] s);
        return (s == '0) ? LAST : s - 1'b1;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= PAUSED;
            resume       <= 1'b0;
            play         <= 1'b0;
            reset_player <= 1'b0;
            song         <= '0;
            // NOTE: edge registers reset high so a button held through reset
            // does not register as a press when reset is released.
            play_q       <= 1'b1;
            next_q       <= 1'b1;
            prev_q       <= 1'b1;
            done_q       <= 1'b1;
        end else begin
            play_q       <= play_button;
            next_q       <= next_button;
            prev_q       <= prev_button;
            done_q       <= song_done;
            reset_player <= 1'b0;

            case (state)
                LOAD: begin
                    // Events in this cycle are dropped; only the edge registers advance.
                    state <= resume ? PLAYING : PAUSED;
                    play  <= resume;
                end

                PLAYING: begin
                    if (done_ev) begin
                        state        <= LOAD;
                        play         <= 1'b0;
                        reset_player <= 1'b1;
                        case (mode)
                            2'd1: begin
                                song   <= inc(song);
                                resume <= 1'b1;
                            end
                            2'd2: resume <= 1'b1;
                            default: begin
                                song   <= inc(song);
                                resume <= 1'b0;
                            end
                        endcase
                    end else if (next_ev || prev_ev) begin
                        state        <= LOAD;
                        play         <= 1'b0;
                        reset_player <= 1'b1;
                        resume       <= KEEP_PLAY_ON_SKIP;
                        song         <= next_ev ? inc(song) : dec(song);
                    end else if (play_ev) begin
                        state <= PAUSED;
                        play  <= 1'b0;
                    end
                end

                PAUSED: begin
                    // song_done is not an event while paused, so it masks nothing.
                    if (next_ev || prev_ev) begin
                        state        <= LOAD;
                        play         <= 1'b0;
                        reset_player <= 1'b1;
                        resume       <= 1'b0;
                        song         <= next_ev ? inc(song) : dec(song);
                    end else if (play_ev) begin
                        state <= PLAYING;
                        play  <= 1'b1;
                    end
                end

                default: begin
                    state <= PAUSED;
                    play  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_playlist_mcu.sv
// Scoreboard bench for playlist_mcu: two instances (skip keeps / drops play state)
// share stimulus; an abstract model queues expected outputs that a monitor compares.
module tb_playlist_mcu;

    localparam int N  = 5;
    localparam int SW = 3;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic play_button = 1'b1, next_button = 1'b0, prev_button = 1'b0, song_done = 1'b0;
    logic [1:0] mode = 2'd0;
    logic play0, rp0, play1, rp1;
    logic [SW-1:0] song0, song1;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    playlist_mcu #(.NUM_SONGS(N), .KEEP_PLAY_ON_SKIP(1'b0)) dut0 (
        .clk(clk), .reset(reset), .play_button(play_button), .next_button(next_button),
        .prev_button(prev_button), .song_done(song_done), .mode(mode),
        .play(play0), .reset_player(rp0), .song(song0));

    playlist_mcu #(.NUM_SONGS(N), .KEEP_PLAY_ON_SKIP(1'b1)) dut1 (
        .clk(clk), .reset(reset), .play_button(play_button), .next_button(next_button),
        .prev_button(prev_button), .song_done(song_done), .mode(mode),
        .play(play1), .reset_player(rp1), .song(song1));

    // Reference model: per-instance song number, playing flag, loading flag, resume flag.
    int m_song[2];
    bit m_play[2], m_load[2], m_resume[2];
    bit lp = 1'b1, ln = 1'b1, lv = 1'b1, ld = 1'b1;

    logic [SW+1:0] exp_q0[$];
    logic [SW+1:0] exp_q1[$];

    task automatic check(input string name, input logic [SW+1:0] got, input logic [SW+1:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got play=%0b reset_player=%0b song=%0d, expected play=%0b reset_player=%0b song=%0d",
                     name, got[SW+1], got[SW], got[SW-1:0], want[SW+1], want[SW], want[SW-1:0]);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_song[k] = 0; m_play[k] = 0; m_load[k] = 0; m_resume[k] = 0;
        end
        lp = 1; ln = 1; lv = 1; ld = 1;
    endtask

    task automatic model_step(input int k, input bit keep, input bit pe, input bit ne,
                              input bit ve, input bit de, input logic [1:0] md);
        if (m_load[k]) begin
            m_load[k] = 0;
            m_play[k] = m_resume[k];
        end else if (m_play[k]) begin
            if (de) begin
                if (md == 2'd2) m_resume[k] = 1;
                else begin
                    m_song[k]   = (m_song[k] + 1) % N;
                    m_resume[k] = (md == 2'd1);
                end
                m_load[k] = 1; m_play[k] = 0;
            end else if (ne || ve) begin
                m_song[k]   = ne ? (m_song[k] + 1) % N : (m_song[k] + N - 1) % N;
                m_resume[k] = keep;
                m_load[k] = 1; m_play[k] = 0;
            end else if (pe) begin
                m_play[k] = 0;
            end
        end else begin
            if (ne || ve) begin
                m_song[k]   = ne ? (m_song[k] + 1) % N : (m_song[k] + N - 1) % N;
                m_resume[k] = 0;
                m_load[k]   = 1;
            end else if (pe) begin
                m_play[k] = 1;
            end
        end
    endtask

    function automatic logic [SW+1:0] expected(input int k);
        return {m_play[k], m_load[k], SW'(m_song[k])};
    endfunction

    // Drive one clock's worth of inputs and queue the outputs expected after that edge.
    task automatic cycle(input bit pb, input bit nb, input bit vb, input bit sd,
                         input logic [1:0] md, input bit rst);
        bit pe, ne, ve, de;
        @(negedge clk);
        play_button = pb; next_button = nb; prev_button = vb; song_done = sd;
        mode = md; reset = rst;
        if (rst) model_reset();
        else begin
            pe = pb && !lp; ne = nb && !ln; ve = vb && !lv; de = sd && !ld;
            lp = pb; ln = nb; lv = vb; ld = sd;
            model_step(0, 1'b0, pe, ne, ve, de, md);
            model_step(1, 1'b1, pe, ne, ve, de, md);
        end
        exp_q0.push_back(expected(0));
        exp_q1.push_back(expected(1));
    endtask

    task automatic idle(input logic [1:0] md);
        cycle(0, 0, 0, 0, md, 0);
    endtask

    // Reset, skip forward to song s while paused, then start playing.
    task automatic goto_playing(input int s);
        cycle(0, 0, 0, 0, 0, 1);
        idle(0);
        for (int i = 0; i < s; i++) begin
            cycle(0, 1, 0, 0, 0, 0);
            idle(0);
        end
        cycle(1, 0, 0, 0, 0, 0);
        idle(0);
    endtask

    // Monitor: outputs are valid every cycle; compare 1 time unit after each edge.
    initial begin
        logic [SW+1:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q0.size() > 0) begin
                e = exp_q0.pop_front();
                check("dut0_outputs", {play0, rp0, song0}, e);
            end
            if (exp_q1.size() > 0) begin
                e = exp_q1.pop_front();
                check("dut1_outputs", {play1, rp1, song1}, e);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        bit pb, nb, vb, sd;
        model_reset();

        // Play button held through reset release must not start playback.
        cycle(1, 0, 0, 0, 0, 1);
        cycle(1, 0, 0, 0, 0, 1);
        repeat (3) cycle(1, 0, 0, 0, 0, 0);
        idle(0);
        cycle(1, 0, 0, 0, 0, 0);
        idle(0);
        cycle(1, 0, 0, 0, 0, 0);
        idle(0);

        // Five skips forward while paused wrap 0->1->2->3->4->0.
        for (int i = 0; i < N; i++) begin
            cycle(0, 1, 0, 0, 0, 0);
            idle(0);
        end

        // Skip back from 0 wraps to the last song; then skip back while playing.
        cycle(0, 0, 1, 0, 0, 0);
        idle(0);
        cycle(1, 0, 0, 0, 0, 0);
        idle(0);
        cycle(0, 0, 1, 0, 0, 0);
        idle(0);
        idle(0);

        // song_done in each mode from song 1, then song_done + next together.
        goto_playing(1); cycle(0, 0, 0, 1, 2'd0, 0); idle(0); idle(0);
        goto_playing(1); cycle(0, 0, 0, 1, 2'd1, 0); idle(0); idle(0);
        goto_playing(1); cycle(0, 0, 0, 1, 2'd2, 0); idle(0); idle(0);
        goto_playing(1); cycle(0, 0, 0, 1, 2'd3, 0); idle(0); idle(0);
        goto_playing(2); cycle(0, 1, 0, 1, 2'd0, 0); idle(0); idle(0);

        // Reset asserted during LOAD clears outputs without waiting for a clock.
        goto_playing(1);
        cycle(0, 1, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 1);
        #1;
        check("async_reset_dut0", {play0, rp0, song0}, '0);
        check("async_reset_dut1", {play1, rp1, song1}, '0);
        idle(0);
        cycle(0, 0, 0, 1, 2'd1, 0);
        idle(0);
        idle(0);

        // Randomised level toggling with occasional resets.
        pb = 0; nb = 0; vb = 0; sd = 0;
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(3) == 0) pb = !pb;
            if ($urandom_range(5) == 0) nb = !nb;
            if ($urandom_range(5) == 0) vb = !vb;
            if ($urandom_range(3) == 0) sd = !sd;
            cycle(pb, nb, vb, sd, 2'($urandom_range(3)), $urandom_range(149) == 0);
        end

        idle(0);
        @(negedge clk);
        @(negedge clk);
        vectors++;
        if (exp_q0.size() != 0 || exp_q1.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: %0d/%0d entries left, expected 0",
                     exp_q0.size(), exp_q1.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/playlist_mcu.md
Name: playlist_mcu

Overview:
Parametrised successor to the player control unit. Tracks the current song index and play/pause state, and accepts play, next, prev and song_done events. Supports NUM_SONGS values that are not powers of two, three playback modes, internal button edge detection, and a one-cycle reset_player pulse issued through a dedicated LOAD state. Sits between the debounced front-panel buttons and the note player.

Parameters:
NUM_SONGS, 4, number of songs; must be >= 2; index range 0..NUM_SONGS-1.
KEEP_PLAY_ON_SKIP, 0, 0: next/prev always leave the player paused; 1: next/prev keep the current play/pause state.

Ports:
clk  input  1  system clock, all state on the rising edge.
reset  input  1  asynchronous, active-high reset.
play_button  input  1  level input; a rising edge is a play/pause toggle request.
next_button  input  1  level input; a rising edge is a skip-forward request.
prev_button  input  1  level input; a rising edge is a skip-backward request.
song_done  input  1  level input from the player; a rising edge means the current song has finished.
mode  input  2  0 NORMAL, 1 AUTOPLAY, 2 REPEAT_ONE, 3 treated as NORMAL.
play  output  1  high while the player must run.
reset_player  output  1  one-cycle pulse that restarts the player at the start of the song.
song  output  $clog2(NUM_SONGS)  current song index.

Behaviour:
- Clock, reset and outputs:
  - Single clock domain; reset is asynchronous and active-high.
  - All outputs are registered.
  - Reset values: play=0, song=0, reset_player=0, state=PAUSED.
  - The edge-detect registers for all four inputs reset to 1, so an input held high through reset does not fire on release.
- Edge detection:
  - An event is in_q==0 && in==1 at a clock edge.
  - The state update happens on that same edge, so outputs change 1 edge after the input rises.
- States:
  - PAUSED: play=0.
  - PLAYING: play=1.
  - LOAD: lasts exactly one cycle; reset_player=1; play=0. The target state (resume flag) is latched on entry.
- Event priority when several events fire on the same edge: song_done > next > prev > play. Lower-priority events on that edge are discarded.
- PAUSED:
  - play event -> PLAYING.
  - next event: song=inc(song) -> LOAD, resume=KEEP_PLAY_ON_SKIP ? 0 : 0. PAUSED stays paused.
  - prev event: song=dec(song) -> LOAD, resume=0.
  - song_done is ignored.
- PLAYING:
  - play event -> PAUSED.
  - next event: song=inc(song) -> LOAD, resume=KEEP_PLAY_ON_SKIP.
  - prev event: song=dec(song) -> LOAD, resume=KEEP_PLAY_ON_SKIP.
  - song_done event, action depends on mode sampled on that edge:
    - NORMAL: song=inc(song), resume=0.
    - AUTOPLAY: song=inc(song), resume=1.
    - REPEAT_ONE: song unchanged, resume=1.
    - All three enter LOAD.
- LOAD:
  - Next cycle -> PLAYING if resume=1, else PAUSED.
  - All events arriving in LOAD are dropped. Edge registers still update, so a level held across LOAD does not fire later.
- Index arithmetic:
  - inc(s) = (s==NUM_SONGS-1) ? 0 : s+1.
  - dec(s) = (s==0) ? NUM_SONGS-1 : s-1.
  - song never takes a value >= NUM_SONGS.
- song changes on the same edge that enters LOAD, so reset_player is high during the first cycle of the new index.
- A mode change takes effect only at the next song_done event.
- Reset asserted mid-LOAD or mid-play: immediate return to reset values; any pending resume flag is cleared.

Test Plan:
- Reset with play_button held high, then release reset and keep it high -> play stays 0, song=0. Drop, then raise play_button -> play=1 one edge later.
- NUM_SONGS=5, PAUSED at song 0; issue 5 next events -> song sequence 1,2,3,4,0. reset_player pulses once per event, exactly one cycle wide. play stays 0.
- NUM_SONGS=5, song 0; prev event -> song=4, play=0. Then play, then prev with KEEP_PLAY_ON_SKIP=1 -> song=3, reset_player pulse, then play=1 after LOAD.
- PLAYING song 1, song_done pulse in each mode:
  - NORMAL -> song=2, play=0.
  - AUTOPLAY -> song=2, play=1 after one LOAD cycle.
  - REPEAT_ONE -> song=1, reset_player=1, play=1.
- song_done and next_button rise on the same edge while PLAYING song 2, NORMAL -> song=3 only (single increment), play=0.
- Assert reset during the LOAD cycle -> play=0, song=0, reset_player=0 immediately. song_done pulse while PAUSED -> no change.
